seq_alu: RTL and testbench

//  Multi-cycle, width-parametrised successor to the combinational 16-bit ALU. Executes the
//  `ALU_* opcode set from alu_ops.v. Operands enter on a valid/ready request port; results

---
 rtl/seq_alu_pkg.sv | 50 +++++
 rtl/seq_alu_muldiv.sv | 84 ++++++++
 rtl/seq_alu.sv | 220 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode map, flag bit positions and FSM encoding for the sequential ALU.
package seq_alu_pkg;

  localparam logic [5:0] ALU_NOP = 6'h00;
  localparam logic [5:0] ALU_ADD = 6'h01;
  localparam logic [5:0] ALU_SUB = 6'h02;
  localparam logic [5:0] ALU_INC = 6'h03;
  localparam logic [5:0] ALU_DEC = 6'h04;
  localparam logic [5:0] ALU_AND = 6'h05;
  localparam logic [5:0] ALU_OR  = 6'h06;
  localparam logic [5:0] ALU_XOR = 6'h07;
  localparam logic [5:0] ALU_NOT = 6'h08;
  localparam logic [5:0] ALU_LSL = 6'h09;
  localparam logic [5:0] ALU_LSR = 6'h0A;
  localparam logic [5:0] ALU_RSL = 6'h0B;
  localparam logic [5:0] ALU_RSR = 6'h0C;
  localparam logic [5:0] ALU_CMP = 6'h0D;
  localparam logic [5:0] ALU_TST = 6'h0E;
  localparam logic [5:0] ALU_MUL = 6'h0F;
  localparam logic [5:0] ALU_DIV = 6'h10;
  localparam logic [5:0] ALU_MOD = 6'h11;

  localparam int ALU_FLAG_Z = 3;
  localparam int ALU_FLAG_N = 2;
  localparam int ALU_FLAG_C = 1;
  localparam int ALU_FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Divide by zero is resolved in one cycle, so only a non-zero divisor uses the iterative unit.
  function automatic logic is_iter_op(input logic [5:0] op, input logic b_zero);
    return (op == ALU_MUL) || (((op == ALU_DIV) || (op == ALU_MOD)) && !b_zero);
  endfunction

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f             = '0;
    f[ALU_FLAG_Z] = z;
    f[ALU_FLAG_N] = n;
    f[ALU_FLAG_C] = c;
    f[ALU_FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle for WIDTH cycles.
// done_o is asserted combinationally during the final iteration; lo_o/hi_o then show the finished value.
module seq_alu_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q, busy_d;
  logic               div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_nxt;

  // Multiplier sits in the low half of acc and is consumed LSB first.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

  // Remainder grows in the high half while dividend bits shift in; quotient bits fill from the LSB.
  assign div_diff = rem_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign div_nxt  = div_diff[WIDTH] ? {rem_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], rem_q[WIDTH-2:0], 1'b1};

  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    rem_d  = rem_q;
    if (start_i) begin
      busy_d = 1'b1;
      div_d  = div_i;
      cnt_d  = '0;
      opnd_d = div_i ? b_i : a_i;
      acc_d  = {{WIDTH{1'b0}}, b_i};
      rem_d  = {{WIDTH{1'b0}}, a_i};
    end else if (busy_q) begin
      if (div_q) rem_d = div_nxt;
      else       acc_d = mul_nxt;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      rem_q  <= rem_d;
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign lo_o   = div_q ? div_nxt[WIDTH-1:0]       : mul_nxt[WIDTH-1:0];
  assign hi_o   = div_q ? div_nxt[2*WIDTH-1:WIDTH] : mul_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: 1-cycle latency for simple ops, WIDTH+1 for MUL/DIV/MOD; valid/ready on both ports.
// A new request may be accepted in the same cycle the held response is consumed.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             res_we,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0]   WIDTH_L = (SHW + 1)'(WIDTH);
  localparam logic [WIDTH:0] ONE_W   = (WIDTH + 1)'(1);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             we_q, we_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept, iter;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign in_ready = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign iter     = is_iter_op(opcode, b == '0);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept && iter),
    .div_i   (opcode != ALU_MUL),
    .a_i     (a),
    .b_i     (b),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  logic [SHW-1:0]   amt;
  logic [SHW:0]     amt_inv;
  logic [WIDTH:0]   shl_w, shr_w;
  logic [WIDTH-1:0] rot_l, rot_r;

  // Shifting one guard bit alongside a exposes the last bit pushed out; it stays 0 for amount 0.
  assign amt     = b[SHW-1:0];
  assign amt_inv = WIDTH_L - {1'b0, amt};
  assign shl_w   = {1'b0, a} << amt;
  assign shr_w   = {a, 1'b0} >> amt;
  assign rot_l   = (a << amt) | (a >> amt_inv);
  assign rot_r   = (a >> amt) | (a << amt_inv);

  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_c, sc_v, sc_we, sc_nop;
  logic [3:0]       sc_flags;

  always_comb begin
    sum_w  = '0;
    sc_res = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_we  = 1'b1;
    sc_nop = 1'b0;
    case (opcode)
      ALU_ADD: begin
        sum_w  = {1'b0, a} + {1'b0, b};
        sc_res = sum_w[WIDTH-1:0];
        sc_c   = sum_w[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB, ALU_CMP: begin
        sum_w  = {1'b0, a} - {1'b0, b};
        sc_res = sum_w[WIDTH-1:0];
        sc_c   = sum_w[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
        sc_we  = (opcode == ALU_SUB);
      end
      ALU_INC: begin
        sum_w  = {1'b0, a} + ONE_W;
        sc_res = sum_w[WIDTH-1:0];
        sc_c   = sum_w[WIDTH];
        sc_v   = !a[WIDTH-1] && sc_res[WIDTH-1];
      end
      ALU_DEC: begin
        sum_w  = {1'b0, a} - ONE_W;
        sc_res = sum_w[WIDTH-1:0];
        sc_c   = sum_w[WIDTH];
        sc_v   = a[WIDTH-1] && !sc_res[WIDTH-1];
      end
      ALU_AND: sc_res = a & b;
      ALU_OR:  sc_res = a | b;
      ALU_XOR: sc_res = a ^ b;
      ALU_NOT: sc_res = ~a;
      ALU_LSL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      ALU_LSR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
      ALU_RSL: begin
        sc_res = rot_l;
        sc_c   = (amt != '0) && rot_l[0];
      end
      ALU_RSR: begin
        sc_res = rot_r;
        sc_c   = (amt != '0) && rot_r[WIDTH-1];
      end
      ALU_TST: begin
        sc_res = a & b;
        sc_we  = 1'b0;
      end
      // Only reached with b == 0; non-zero divisors go through the iterative unit.
      ALU_DIV: begin
        sc_res = '1;
        sc_hi  = a;
        sc_v   = 1'b1;
      end
      ALU_MOD: begin
        sc_res = a;
        sc_hi  = '1;
        sc_v   = 1'b1;
      end
      default: begin
        sc_we  = 1'b0;
        sc_nop = 1'b1;
      end
    endcase
    sc_flags = sc_nop ? 4'b0000
                      : pack_flags(sc_res == '0, sc_res[WIDTH-1], sc_c, sc_v);
  end

  logic [WIDTH-1:0] md_res, md_res_hi;
  logic [3:0]       md_flags;

  always_comb begin
    md_res    = md_lo;
    md_res_hi = md_hi;
    if (op_q == ALU_MOD) begin
      md_res    = md_hi;
      md_res_hi = md_lo;
    end
    md_flags = pack_flags(md_res == '0, md_res[WIDTH-1],
                          (op_q == ALU_MUL) && (md_hi != '0), 1'b0);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    hi_d    = hi_q;
    we_d    = we_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = iter ? ST_CALC : ST_DONE;
      ST_CALC: if (md_done) state_d = ST_DONE;
      ST_DONE: begin
        if (accept)         state_d = iter ? ST_CALC : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      op_d = opcode;
      if (!iter) begin
        res_d   = sc_res;
        hi_d    = sc_hi;
        we_d    = sc_we;
        flags_d = sc_flags;
      end
    end else if ((state_q == ST_CALC) && md_done) begin
      res_d   = md_res;
      hi_d    = md_res_hi;
      we_d    = 1'b1;
      flags_d = md_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_NOP;
      res_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign result_hi = hi_q;
  assign res_we    = we_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed and randomized bench for seq_alu (WIDTH=16) against an arithmetic reference model.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result, result_hi;
  logic        res_we;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  int cur_op = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .res_we    (res_we),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        we;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [5:0] op, input logic [15:0] x, input logic [15:0] y);
    exp_t        e;
    int unsigned ua, ub, full;
    int          sa, sb, ss, amt;
    logic        c, v, nof;
    ua = x; ub = y;
    sa = int'($signed(x)); sb = int'($signed(y));
    amt = int'(y[3:0]);
    c = 1'b0; v = 1'b0; nof = 1'b0;
    e.res = '0; e.hi = '0; e.we = 1'b1; e.lat = 1;
    case (op)
      ALU_ADD: begin full = ua + ub; e.res = full[15:0]; c = full[16];
                     ss = sa + sb; v = (ss > 32767) || (ss < -32768); end
      ALU_SUB, ALU_CMP: begin e.res = 16'(ua - ub); c = (ua < ub);
                     ss = sa - sb; v = (ss > 32767) || (ss < -32768);
                     e.we = (op == ALU_SUB); end
      ALU_INC: begin full = ua + 1; e.res = full[15:0]; c = full[16]; v = (sa == 32767); end
      ALU_DEC: begin e.res = 16'(ua - 1); c = (ua == 0); v = (sa == -32768); end
      ALU_AND: e.res = x & y;
      ALU_OR:  e.res = x | y;
      ALU_XOR: e.res = x ^ y;
      ALU_NOT: e.res = ~x;
      ALU_LSL: begin full = ua << amt; e.res = full[15:0]; c = full[16]; end
      ALU_LSR: begin e.res = 16'(ua >> amt); c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
      ALU_RSL: begin full = (ua << amt) | (ua >> (16 - amt)); e.res = full[15:0];
                     c = (amt != 0) && (((ua >> (16 - amt)) & 1) != 0); end
      ALU_RSR: begin full = (ua >> amt) | (ua << (16 - amt)); e.res = full[15:0];
                     c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
      ALU_TST: begin e.res = x & y; e.we = 1'b0; end
      ALU_MUL: begin full = ua * ub; e.res = full[15:0]; e.hi = full[31:16];
                     c = (e.hi != 0); e.lat = 17; end
      ALU_DIV: if (ub == 0) begin e.res = 16'hFFFF; e.hi = x; v = 1'b1; end
               else begin e.res = 16'(ua / ub); e.hi = 16'(ua % ub); e.lat = 17; end
      ALU_MOD: if (ub == 0) begin e.res = x; e.hi = 16'hFFFF; v = 1'b1; end
               else begin e.res = 16'(ua % ub); e.hi = 16'(ua / ub); e.lat = 17; end
      default: begin e.we = 1'b0; nof = 1'b1; end
    endcase
    e.fl = nof ? 4'b0000 : {e.res == 16'h0, e.res[15], c, v};
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s op=%0h: observed %0h expected %0h", tag, cur_op, obs, expv);
    end
  endtask

  task automatic run_op(input logic [5:0] op, input logic [15:0] x, input logic [15:0] y,
                        input bit hold);
    exp_t e;
    int   n, lat;
    bit   busy_ok;
    e = model(op, x, y);
    cur_op = int'(op);
    @(negedge clk);
    in_valid = 1'b1; opcode = op; a = x; b = y; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = 6'($urandom); a = 16'($urandom); b = 16'($urandom);
    busy_ok = 1'b1;
    @(negedge clk); lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk); lat++;
    end
    check("out_valid", 64'(out_valid), 64'(1));
    check("latency",   64'(lat),       64'(e.lat));
    check("busy_gate", 64'(busy_ok),   64'(1));
    check("result",    64'(result),    64'(e.res));
    check("result_hi", 64'(result_hi), 64'(e.hi));
    check("res_we",    64'(res_we),    64'(e.we));
    check("flags",     64'(flags),     64'(e.fl));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("hold", 64'({out_valid, result, result_hi, res_we, flags}),
                      64'({1'b1, e.res, e.hi, e.we, e.fl}));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t        e;
    logic [15:0] xs [5];
    logic [15:0] ys [5];
    int          n;
    logic [5:0]  rop;
    logic [15:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(0));
    check("rst_outputs",   64'({result, result_hi, res_we, flags}), 64'(0));
    rst = 1'b0;

    run_op(ALU_ADD, 16'h7FFF, 16'h0001, 1'b0);
    run_op(ALU_SUB, 16'd10,   16'd1,    1'b0);
    run_op(ALU_CMP, 16'd1,    16'd10,   1'b0);
    run_op(ALU_TST, 16'h00F0, 16'h0F00, 1'b0);
    run_op(ALU_MUL, 16'h1234, 16'h0100, 1'b0);
    run_op(ALU_DIV, 16'd100,  16'd7,    1'b0);
    run_op(ALU_MOD, 16'd100,  16'd7,    1'b0);
    run_op(ALU_DIV, 16'd5,    16'd0,    1'b0);
    run_op(ALU_MOD, 16'd5,    16'd0,    1'b0);
    run_op(ALU_RSL, 16'h8001, 16'h0001, 1'b0);
    run_op(ALU_LSR, 16'h8001, 16'h0014, 1'b0);
    run_op(ALU_LSL, 16'hBEEF, 16'h0010, 1'b0);
    run_op(ALU_DEC, 16'h8000, 16'h0000, 1'b0);
    run_op(ALU_INC, 16'hFFFF, 16'h0000, 1'b0);
    run_op(ALU_NOP, 16'h1234, 16'h5678, 1'b0);
    run_op(6'h3F,   16'h1234, 16'h5678, 1'b0);
    run_op(ALU_ADD, 16'hFFFF, 16'h0001, 1'b1);
    run_op(ALU_MUL, 16'hFFFF, 16'hFFFF, 1'b1);

    // Back-to-back ADDs: one response per cycle with out_ready held high.
    for (int i = 0; i < 5; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
    cur_op = int'(ALU_ADD);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; opcode = ALU_ADD; a = xs[0]; b = ys[0];
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i < 5) begin a = xs[i]; b = ys[i]; end
      else in_valid = 1'b0;
      @(negedge clk);
      e = model(ALU_ADD, xs[i-1], ys[i-1]);
      check("b2b_valid", 64'(out_valid), 64'(1));
      check("b2b_res",   64'({result, flags}), 64'({e.res, e.fl}));
      if (i < 5) check("b2b_ready", 64'(in_ready), 64'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a multiply.
    cur_op = int'(ALU_MUL);
    @(negedge clk);
    in_valid = 1'b1; opcode = ALU_MUL; a = 16'h00FF; b = 16'h00FF;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 64'(out_valid), 64'(0));
    check("rst_mid_ready", 64'(in_ready),  64'(0));
    check("rst_mid_outs",  64'({result, result_hi, res_we, flags}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready),  64'(1));
    check("post_rst_valid", 64'(out_valid), 64'(0));

    for (int k = 0; k < 150; k++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(18, 63)) : 6'($urandom_range(0, 17));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_op(rop, ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
